// File: rtl/cgra_host_load_resp.sv
// cgra_host_load_resp: host scan/load responder decoding requests to tile CMEM/DMEM and sequencing execution
module cgra_host_load_resp #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int NUM_TILES   = 16,
  parameter int CMEM_DEPTH  = 128,
  parameter int DMEM_DEPTH  = 1024,
  parameter int SRAM_RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [ADDR_W-1:0]    address_in,
  input  logic                 data_addr_valid,
  input  logic                 read_write,
  input  logic                 scan_start_exec,
  input  logic                 exec_done_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_out_valid,
  output logic                 busy,
  output logic                 exec_enable,
  output logic                 exec_end,
  output logic                 err_addr,
  output logic                 err_proto,
  output logic [NUM_TILES-1:0] tile_sel,
  output logic                 cmem_we,
  output logic                 cmem_re,
  output logic                 dmem_we,
  output logic                 dmem_re,
  output logic [10:0]          mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RESP, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d, wdata_q, wdata_d;
  logic [10:0] addr_q, addr_d;
  logic [NUM_TILES-1:0] sel_q, sel_d;
  logic dval_q, dval_d, en_q, en_d, end_q, end_d, ea_q, ea_d, ep_q, ep_d, ok_q, ok_d;
  logic cwe_q, cwe_d, cre_q, cre_d, dwe_q, dwe_d, dre_q, dre_d;
  logic [3:0] tile;
  logic space, legal;
  logic [10:0] off;
  assign tile  = address_in[15:12];
  assign space = address_in[11];
  assign off   = address_in[10:0];
  assign legal = (32'(tile) < NUM_TILES) && (space ? 32'(off) < DMEM_DEPTH : 32'(off) < CMEM_DEPTH);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    ok_d    = ok_q;
    en_d    = en_q;
    end_d   = end_q;
    ea_d    = ea_q;
    ep_d    = ep_q;
    sel_d   = '0;
    dval_d  = 1'b0;
    cwe_d   = 1'b0;
    cre_d   = 1'b0;
    dwe_d   = 1'b0;
    dre_d   = 1'b0;
    case (state_q)
      IDLE: if (data_addr_valid) begin
        state_d = read_write ? WR : RD_ISSUE;
        ok_d    = legal;
        addr_d  = off;
        wdata_d = data_in;
        ea_d    = ea_q | ~legal;
        sel_d   = legal ? NUM_TILES'(1) << tile : '0;
        cwe_d   = legal & ~space & read_write;
        dwe_d   = legal & space & read_write;
        cre_d   = legal & ~space & ~read_write;
        dre_d   = legal & space & ~read_write;
      end else if (scan_start_exec) begin
        state_d = EXEC;
        en_d    = 1'b1;
      end
      WR: state_d = IDLE;
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = 2'(SRAM_RD_LAT - 1);
      end
      RD_WAIT: if (cnt_q == 2'd0) begin
        state_d = RESP;
        dval_d  = 1'b1;
        dout_d  = ok_q ? mem_rdata : '0;
      end else cnt_d = cnt_q - 2'd1;
      RESP: state_d = IDLE;
      EXEC: begin
        ep_d = ep_q | data_addr_valid;
        if (!scan_start_exec) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (exec_done_in) begin
          state_d = DONE;
          en_d    = 1'b0;
          end_d   = 1'b1;
        end
      end
      DONE: begin
        ep_d = ep_q | data_addr_valid;
        // exec_end stays up while the level is held so the host cannot re-trigger
        if (!scan_start_exec) begin
          state_d = IDLE;
          end_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      {dval_q, en_q, end_q, ea_q, ep_q, ok_q} <= '0;
      {cwe_q, cre_q, dwe_q, dre_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      {dval_q, en_q, end_q, ea_q, ep_q, ok_q} <= {dval_d, en_d, end_d, ea_d, ep_d, ok_d};
      {cwe_q, cre_q, dwe_q, dre_q} <= {cwe_d, cre_d, dwe_d, dre_d};
    end
  end
  assign busy           = state_q != IDLE;
  assign data_out       = dout_q;
  assign data_out_valid = dval_q;
  assign exec_enable    = en_q;
  assign exec_end       = end_q;
  assign err_addr       = ea_q;
  assign err_proto      = ep_q;
  assign tile_sel       = sel_q;
  assign cmem_we        = cwe_q;
  assign cmem_re        = cre_q;
  assign dmem_we        = dwe_q;
  assign dmem_re        = dre_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
endmodule

// File: tb/tb_cgra_host_load_resp.sv
// tb_cgra_host_load_resp: directed checks of the load responder at read latency 1 and 3
module tb_cgra_host_load_resp;
  logic clk = 0, reset = 1;
  logic [63:0] data_in = '0;
  logic [15:0] address_in = '0;
  logic data_addr_valid = 0, read_write = 0, scan_start_exec = 0, exec_done_in = 0;
  logic [63:0] data_out, mem_wdata, mem_rdata, data_out3, mem_wdata3, mem_rdata3;
  logic data_out_valid, busy, exec_enable, exec_end, err_addr, err_proto;
  logic cmem_we, cmem_re, dmem_we, dmem_re;
  logic data_out_valid3, busy3, exec_enable3, exec_end3, err_addr3, err_proto3;
  logic cmem_we3, cmem_re3, dmem_we3, dmem_re3;
  logic [15:0] tile_sel, tile_sel3;
  logic [10:0] mem_addr, mem_addr3;
  logic [63:0] p3a, p3b;
  int total = 0, bad = 0, pulses;
  always #5 clk = ~clk;
  cgra_host_load_resp dut (
    .clk(clk), .reset(reset), .data_in(data_in), .address_in(address_in),
    .data_addr_valid(data_addr_valid), .read_write(read_write),
    .scan_start_exec(scan_start_exec), .exec_done_in(exec_done_in),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .exec_enable(exec_enable), .exec_end(exec_end), .err_addr(err_addr),
    .err_proto(err_proto), .tile_sel(tile_sel), .cmem_we(cmem_we), .cmem_re(cmem_re),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  cgra_host_load_resp #(.SRAM_RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .data_in(data_in), .address_in(address_in),
    .data_addr_valid(data_addr_valid), .read_write(read_write),
    .scan_start_exec(scan_start_exec), .exec_done_in(exec_done_in),
    .data_out(data_out3), .data_out_valid(data_out_valid3), .busy(busy3),
    .exec_enable(exec_enable3), .exec_end(exec_end3), .err_addr(err_addr3),
    .err_proto(err_proto3), .tile_sel(tile_sel3), .cmem_we(cmem_we3), .cmem_re(cmem_re3),
    .dmem_we(dmem_we3), .dmem_re(dmem_re3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );
  // SRAM models: 64'h1234 exactly RD_LAT cycles after re, a nonzero filler otherwise
  always @(posedge clk) begin
    mem_rdata <= (cmem_re | dmem_re) ? 64'h1234 : 64'hBAD0;
    p3a <= (cmem_re3 | dmem_re3) ? 64'h1234 : 64'hBAD0;
    p3b <= p3a;
    mem_rdata3 <= p3b;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dval", 64'(data_out_valid), 64'd0);
    chk("rst_dout", data_out, 64'd0);
    chk("rst_errs", 64'({err_addr, err_proto, exec_enable, exec_end}), 64'd0);
    chk("rst_sel", 64'(tile_sel), 64'd0);
    reset = 0;
    step();
    data_in = 64'hDEAD_BEEF_0000_0001; address_in = 16'h3805; read_write = 1; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    chk("wr_dmem_we", 64'(dmem_we), 64'd1);
    chk("wr_cmem_we", 64'(cmem_we), 64'd0);
    chk("wr_sel", 64'(tile_sel), 64'h0008);
    chk("wr_addr", 64'(mem_addr), 64'd5);
    chk("wr_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
    chk("wr_busy", 64'(busy), 64'd1);
    step();
    chk("wr_busy_t2", 64'(busy), 64'd0);
    chk("wr_we_t2", 64'(dmem_we), 64'd0);
    address_in = 16'h0010; read_write = 0; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    chk("rd_re_t1", 64'(cmem_re), 64'd1);
    chk("rd_dre_t1", 64'(dmem_re), 64'd0);
    chk("rd_dval_t1", 64'(data_out_valid), 64'd0);
    step();
    chk("rd_re_t2", 64'(cmem_re), 64'd0);
    chk("rd_dval_t2", 64'(data_out_valid), 64'd0);
    step();
    chk("rd_dval_t3", 64'(data_out_valid), 64'd1);
    chk("rd_dout_t3", data_out, 64'h1234);
    chk("rd3_dval_t3", 64'(data_out_valid3), 64'd0);
    step();
    chk("rd_dval_t4", 64'(data_out_valid), 64'd0);
    chk("rd_hold_t4", data_out, 64'h1234);
    chk("rd3_dval_t4", 64'(data_out_valid3), 64'd0);
    step();
    chk("rd3_dval_t5", 64'(data_out_valid3), 64'd1);
    chk("rd3_dout_t5", data_out3, 64'h1234);
    step();
    chk("rd3_busy_t6", 64'(busy3), 64'd0);
    address_in = 16'h0090; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    chk("ill_err", 64'(err_addr), 64'd1);
    chk("ill_strobe", 64'({cmem_re, dmem_re, cmem_we, dmem_we}), 64'd0);
    step();
    step();
    chk("ill_dval", 64'(data_out_valid), 64'd1);
    chk("ill_dout", data_out, 64'd0);
    repeat (3) step();
    address_in = 16'h0001; read_write = 1; data_in = 64'h55; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    chk("post_ill_we", 64'(cmem_we), 64'd1);
    chk("post_ill_err", 64'(err_addr), 64'd1);
    step();
    address_in = 16'h1002; data_addr_valid = 1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("b2b_we", 64'(cmem_we), 64'(k % 2));
      pulses += int'(cmem_we);
    end
    data_addr_valid = 0;
    chk("b2b_count", 64'(pulses), 64'd4);
    step();
    chk("b2b_idle", 64'(busy), 64'd0);
    scan_start_exec = 1;
    step();
    chk("ex_en", 64'(exec_enable), 64'd1);
    chk("ex_busy", 64'(busy), 64'd1);
    address_in = 16'h3805; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    chk("ex_proto", 64'(err_proto), 64'd1);
    chk("ex_nostrobe", 64'({cmem_we, dmem_we, cmem_re, dmem_re}), 64'd0);
    exec_done_in = 1;
    step();
    exec_done_in = 0;
    chk("ex_end", 64'(exec_end), 64'd1);
    chk("ex_en_off", 64'(exec_enable), 64'd0);
    repeat (24) step();
    chk("ex_end_held", 64'(exec_end), 64'd1);
    chk("ex_busy_held", 64'(busy), 64'd1);
    scan_start_exec = 0;
    step();
    chk("ex_end_drop", 64'(exec_end), 64'd0);
    chk("ex_busy_drop", 64'(busy), 64'd0);
    scan_start_exec = 1;
    step();
    chk("ab_en", 64'(exec_enable), 64'd1);
    exec_done_in = 0;
    step();
    step();
    scan_start_exec = 0;
    step();
    chk("ab_en_off", 64'(exec_enable), 64'd0);
    chk("ab_no_end", 64'(exec_end), 64'd0);
    chk("ab_idle", 64'(busy), 64'd0);
    address_in = 16'h1003; read_write = 1; data_addr_valid = 1; scan_start_exec = 1;
    step();
    data_addr_valid = 0;
    chk("both_we", 64'(cmem_we), 64'd1);
    chk("both_en_t1", 64'(exec_enable), 64'd0);
    step();
    chk("both_en_t2", 64'(exec_enable), 64'd0);
    step();
    chk("both_en_t3", 64'(exec_enable), 64'd1);
    scan_start_exec = 0;
    repeat (4) step();
    address_in = 16'h0010; read_write = 0; data_addr_valid = 1;
    step();
    data_addr_valid = 0;
    step();
    reset = 1;
    step();
    chk("rr_dval", 64'(data_out_valid), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_dout", data_out, 64'd0);
    chk("rr_flags", 64'({err_addr, err_proto, cmem_re, tile_sel}), 64'd0);
    reset = 0;
    step();
    chk("rr_dval_after", 64'(data_out_valid), 64'd0);
    step();
    chk("rr_dval_after2", 64'(data_out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
